// File: rtl/cnt_job_arbiter_pkg.sv
// rtl/cnt_job_arbiter_pkg.sv - shared state encoding and default sizes for the job arbiter
package cnt_job_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int CNT_W_DEF   = 7;
    localparam int ID_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cnt_job_arbiter_rr_pick.sv
// rtl/cnt_job_arbiter_rr_pick.sv - combinational round-robin pick starting after the last winner
module rr_pick
    import cnt_job_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit after last wins.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx]) begin
                valid = 1'b1;
                id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cnt_job_arbiter.sv
// rtl/cnt_job_arbiter.sv - round-robin arbiter handing count jobs to one shared counter
module cnt_job_arbiter
    import cnt_job_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*CNT_W-1:0] i_num_cnt_flat,
    input  logic                     i_idle,
    input  logic                     i_done,
    output logic [NUM_REQ-1:0]       o_ack,
    output logic                     o_busy,
    output logic [1:0]               o_grant_id,
    output logic                     o_run,
    output logic [CNT_W-1:0]         o_num_cnt
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [CNT_W-1:0]  pick_cnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (i_req),
        .last  (last_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    assign pick_cnt = i_num_cnt_flat[CNT_W*pick_id +: CNT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // Grants wait for the counter to be idle; the count is captured only here.
                if (i_idle && pick_valid) begin
                    id_d    = pick_id;
                    cnt_d   = pick_cnt;
                    state_d = (pick_cnt == '0) ? ST_ACK : ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_done) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                last_d  = id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ack = '0;
        if (state_q == ST_ACK) begin
            o_ack[id_q] = 1'b1;
        end
    end

    assign o_run      = (state_q == ST_LAUNCH);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_grant_id = id_q;
    assign o_num_cnt  = cnt_q;

endmodule
